// File: rtl/sfifo_pkg.sv
// Shared types and elaboration helpers for the sfifo stream buffer.
package sfifo_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CNT_W  = $clog2(DEF_DEPTH) + 1;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_CNT_W-1:0]  cnt_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/sfifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module sfifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sfifo.sv
// Valid/ready stream FIFO with registered head beat and registered s_ready.
// One-cycle minimum latency, no bypass; s_ready is !full of the post-edge state.
module sfifo
  import sfifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int AW = CNT_W - 1;

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sfifo: DEPTH must be a power of two and at least 2");
  end

  logic [CNT_W-1:0]  wr_ptr, rd_ptr, head_ptr, count_nxt;
  logic [DATA_W-1:0] rdata, head_dat;
  logic              push, pop;

  assign push  = s_valid & s_ready;
  assign pop   = m_valid & m_ready;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);

  // Head after this edge; when it is the slot being written now, take the write data.
  assign head_ptr = pop ? rd_ptr + CNT_W'(1) : rd_ptr;
  assign head_dat = (push && (wr_ptr == head_ptr)) ? s_data : rdata;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  sfifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(s_data),
    .raddr(head_ptr[AW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      rd_ptr  <= head_ptr;
      count   <= count_nxt;
      s_ready <= (count_nxt != CNT_W'(DEPTH));
      m_valid <= (count_nxt != '0);
      if (pop || (push && empty)) m_data <= head_dat;
    end
  end

  property p_src_hold;
    @(posedge clk) disable iff (reset)
      (s_valid && !s_ready) |=> (s_valid && $stable(s_data));
  endproperty
  a_src_hold: assert property (p_src_hold);
endmodule

// File: tb/tb_sfifo.sv
// Scoreboard bench for sfifo: accepted beats are queued, a negedge monitor pops and compares.
module tb_sfifo;
  import sfifo_pkg::*;

  localparam int DEPTH = DEF_DEPTH;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  s_valid = 1'b0;
  logic  m_ready = 1'b0;
  data_t s_data = '0;
  data_t m_data;
  cnt_t  count;
  logic  s_ready, m_valid, full, empty;

  int    checks = 0;
  int    errors = 0;
  int    pops = 0;
  data_t exp_q[$];
  logic  ready_armed;

  sfifo dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // s_ready may only be high from the first edge after reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) ready_armed <= 1'b0;
    else       ready_armed <= 1'b1;
  end

  // Monitor: state vs. model occupancy, then compare any pop due at the next edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_count", count, '0);
    end else begin
      chk("count", count, exp_q.size());
      chk("m_valid", m_valid, exp_q.size() != 0);
      chk("full", full, exp_q.size() == DEPTH);
      chk("empty", empty, exp_q.size() == 0);
      chk("s_ready", s_ready, ready_armed && (exp_q.size() < DEPTH));
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got data 0x%0h, expected no beat", m_data);
        end else begin
          data_t e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL m_data: got 0x%0h, expected 0x%0h at %0t", m_data, e, $time);
          end
          pops++;
        end
      end
    end
  end

  // Offer one beat; returns at posedge+1 after acceptance with s_valid still high.
  task automatic offer(input data_t d);
    bit acc, ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end
      #1;
    end
    chk("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_ready", s_ready, 1'b0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_full", full, 1'b0);
    chk("reset_m_data", m_data, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("release_s_ready", s_ready, 1'b1);
    chk("release_count", count, '0);

    // Single beat with consumer ready
    m_ready = 1'b1;
    offer(32'hA5A5_0001);
    s_valid = 1'b0;
    chk("single_m_valid", m_valid, 1'b1);
    chk("single_m_data", m_data, 32'hA5A5_0001);
    @(posedge clk); #1;
    chk("single_count", count, '0);

    // Fill with back-pressure, fifth beat held off, then drain
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(data_t'(32'h10 + i));
    fork
      offer(32'h14);
      begin
        repeat (3) begin @(posedge clk); #1; end
        chk("fill_count", count, 4);
        chk("fill_full", full, 1'b1);
        chk("fill_s_ready", s_ready, 1'b0);
        chk("fill_head", m_data, 32'h10);
        m_ready = 1'b1;
      end
    join
    s_valid = 1'b0;
    wait_drain("drain_done");
    chk("drain_empty", empty, 1'b1);

    // Streaming 0..19 with m_ready toggling
    pops = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) offer(data_t'(i));
        s_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 200 && pops < 20; c++) begin
          m_ready = (c % 2 == 0);
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_drain("stream_drain");
    chk("stream_pops", pops, 20);

    // Randomized traffic
    pops = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
          end
          offer(data_t'($urandom));
        end
        s_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 3000 && pops < 150; c++) begin
          m_ready = 1'($urandom_range(1));
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_drain("random_drain");
    chk("random_pops", pops, 150);

    // Reset mid-stream with three beats stored
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(data_t'(32'hC0 + i));
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pre_count", count, 3);
    reset = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_count", count, '0);
    chk("midrst_s_ready", s_ready, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_ready = 1'b1;
    pops = 0;
    offer(32'h55);
    s_valid = 1'b0;
    chk("midrst_new_valid", m_valid, 1'b1);
    chk("midrst_new_data", m_data, 32'h55);
    wait_drain("midrst_drain");
    chk("midrst_pops", pops, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
